uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 2, giving the number of requesters (2..4).
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port req_valid, input, NUM_REQ bits: per-requester word-available flag.
REQ-005 The module SHALL have port req_data, input, 16*NUM_REQ bits: per-requester result word; requester i uses bits [16i+15:16i].
REQ-006 The module SHALL have port req_wide, input, NUM_REQ bits: 1 = send 2 bytes, 0 = send low byte only.
REQ-007 The module SHALL have port req_ready, output, NUM_REQ bits: one-hot accept strobe.
REQ-008 The module SHALL have port uart_data, output, 8 bits: byte presented to the UART transmitter.
REQ-009 The module SHALL have port uart_start, output, 1 bit: one-cycle start pulse to the UART.
REQ-010 The module SHALL have port uart_busy, input, 1 bit: UART busy flag; it is high from the cycle after uart_start until the stop bit completes.
REQ-011 The module SHALL have port grant_id, output, 2 bits: index of the requester currently owning the UART.
REQ-012 The module SHALL have port active, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SEND_LO, WAIT_LO, SEND_HI and WAIT_HI.
REQ-014 In IDLE with any req_valid set, the arbiter SHALL pick winner g combinationally and drive req_ready[g]=1 in that cycle; all other req_ready bits SHALL stay 0.
REQ-015 Winner selection SHALL be round-robin: search from pointer ptr upward, modulo NUM_REQ, and take the first set req_valid.
REQ-016 On the accept edge the module SHALL capture data_g, wide_g and g into grant_id, set ptr=(g+1) mod NUM_REQ, and go to SEND_LO.
REQ-017 req_ready SHALL be 0 in every state other than IDLE.
REQ-018 A requester SHALL hold valid, data and wide stable until it sees ready; deasserting valid before ready SHALL have no effect.
REQ-019 In SEND_LO with uart_busy=0, the module SHALL drive uart_data=captured[7:0] and uart_start=1 for exactly one cycle, then go to WAIT_LO.
REQ-020 In SEND_LO with uart_busy=1, the module SHALL hold uart_start=0 and remain in SEND_LO.
REQ-021 WAIT_LO SHALL ignore uart_busy in its first cycle.
REQ-022 After that first cycle, WAIT_LO SHALL exit on uart_busy=0: to SEND_HI if wide=1, otherwise to IDLE.
REQ-023 SEND_HI and WAIT_HI SHALL behave as SEND_LO and WAIT_LO using captured[15:8]; WAIT_HI SHALL exit to IDLE.
REQ-024 uart_data SHALL hold its last driven byte between starts.
REQ-025 Requests arriving during a transfer SHALL wait; the earliest re-accept is the cycle after return to IDLE.
REQ-026 Minimum accept-to-accept spacing SHALL be 4 cycles plus UART busy time per byte.
REQ-027 A requester with continuously asserted valid SHALL NOT be served twice while another requester is asserting valid.

Reset
REQ-028 On a reset edge the module SHALL set state=IDLE, ptr=0, grant_id=0, uart_data=0x00, uart_start=0, active=0, req_ready=0 and clear the captured word.
REQ-029 Reset SHALL take priority over all other events, including mid-frame.
REQ-030 On reset mid-frame the module SHALL abandon the frame with no further uart_start; any UART byte already in flight is not recalled.

Structure
REQ-031 The state enum, NUM_REQ default and byte-select constants SHALL live in shared package jsilicon_pkg.
REQ-032 Round-robin winner selection (inputs valid and ptr; outputs one-hot grant and index) SHALL be sub-module rr_arbiter, purely combinational.
REQ-033 The frame sequencing FSM SHALL remain in uart_tx_arbiter.
REQ-034 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-035 Single narrow: valid[0]=1, data0=0x00A5, wide0=0 -> ready[0] pulses once; one uart_start with uart_data=0xA5; return to IDLE.
REQ-036 Single wide: valid[1]=1, data1=0x1234, wide1=1 -> two starts with bytes 0x34 then 0x12; the second start occurs only after busy falls.
REQ-037 Contention: both valid continuously, ptr=0 -> grant order 0,1,0,1 over 4 frames; grant_id matches each frame.
REQ-038 UART busy at entry: hold uart_busy=1 on SEND_LO entry for 10 cycles -> no start until the cycle busy=0; then exactly one start.
REQ-039 Reset mid-frame: assert reset in WAIT_LO of a wide frame -> next cycle state IDLE, all outputs at reset values, no 0x12-byte start afterwards, ptr=0.
REQ-040 Late valid drop: valid[1] deasserted during a requester-0 frame -> requester 1 never receives ready; only the requester-0 frame is sent.

Source files
------------

// File: rtl/jsilicon_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, the default
// requester count and byte-select helpers.
package jsilicon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_LO = 3'd1,
        WAIT_LO = 3'd2,
        SEND_HI = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    localparam int NUM_REQ_DEFAULT = 2;

    localparam logic BYTE_LO = 1'b0;
    localparam logic BYTE_HI = 1'b1;

    function automatic logic [7:0] selectByte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set valid bit found searching
// upward from i_ptr, wrapping modulo NUM_REQ.
module rr_arbiter
    import jsilicon_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_index,
    output logic               o_any
);

    logic [2:0] w_sum;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins
    always_comb begin
        o_grant = '0;
        o_index = 2'd0;
        o_any   = 1'b0;
        w_sum   = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + 3'(k);
            if (w_sum >= 3'(NUM_REQ)) begin
                w_sum = w_sum - 3'(NUM_REQ);
            end
            if (|(i_valid & (NUM_REQ'(1) << w_sum))) begin
                o_grant = NUM_REQ'(1) << w_sum;
                o_index = w_sum[1:0];
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several 16-bit result words onto one byte-wide UART transmitter,
// sending the low byte and, for wide requests, the high byte afterwards.
module uart_tx_arbiter
    import jsilicon_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]     req_wide,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_data,
    output logic                   uart_start,
    input  logic                   uart_busy,
    output logic [1:0]             grant_id,
    output logic                   active
);

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_ptr;
    logic [15:0]  r_word;
    logic         r_wide;
    logic [1:0]   r_grantId;
    logic [7:0]   r_lastByte;
    logic         r_waitFirst;

    logic [NUM_REQ-1:0] w_grant;
    logic [1:0]         w_index;
    logic               w_any;
    logic               w_accept;
    logic               w_start;
    logic [7:0]         w_byte;
    logic [15:0]        w_word;
    logic [2:0]         w_ptrSum;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_index (w_index),
        .o_any   (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any && !reset;
    assign w_word   = 16'(req_data >> {w_index, 4'b0000});
    assign w_ptrSum = {1'b0, w_index} + 3'd1;

    // Frame sequencing; reset suppresses the start strobe so an abandoned frame never emits a byte
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_byte  = selectByte(r_word, BYTE_LO);
        case (r_state)
            IDLE: begin
                if (w_any) w_next = SEND_LO;
            end
            SEND_LO: begin
                if (!uart_busy) begin
                    w_start = 1'b1;
                    w_next  = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!r_waitFirst && !uart_busy) w_next = r_wide ? SEND_HI : IDLE;
            end
            SEND_HI: begin
                w_byte = selectByte(r_word, BYTE_HI);
                if (!uart_busy) begin
                    w_start = 1'b1;
                    w_next  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (!r_waitFirst && !uart_busy) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (reset) w_start = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_word      <= 16'h0000;
            r_wide      <= 1'b0;
            r_grantId   <= 2'd0;
            r_lastByte  <= 8'h00;
            r_waitFirst <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_waitFirst <= w_start;
            if (w_accept) begin
                r_word    <= w_word;
                r_wide    <= |(req_wide & w_grant);
                r_grantId <= w_index;
                r_ptr     <= (w_ptrSum >= 3'(NUM_REQ)) ? 2'd0 : w_ptrSum[1:0];
            end
            if (w_start) r_lastByte <= w_byte;
        end
    end

    assign req_ready  = w_accept ? w_grant : '0;
    assign uart_start = w_start;
    assign uart_data  = w_start ? w_byte : r_lastByte;
    assign grant_id   = r_grantId;
    assign active     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level byte-queue model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int N = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       req_valid = '0;
    logic [16*N-1:0]    req_data = '0;
    logic [N-1:0]       req_wide = '0;
    logic [N-1:0]       req_ready;
    logic [7:0]         uart_data;
    logic               uart_start;
    logic               uart_busy = 1'b0;
    logic [1:0]         grant_id;
    logic               active;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_wide   (req_wide),
        .req_ready  (req_ready),
        .uart_data  (uart_data),
        .uart_start (uart_start),
        .uart_busy  (uart_busy),
        .grant_id   (grant_id),
        .active     (active)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // UART stand-in: busy rises the cycle after a start and stays up busyLen cycles
    int busyLen = 5;
    bit forceBusy = 1'b0;
    int busyCnt = 0;
    bit startSampled;
    initial begin
        forever begin
            @(negedge clock);
            startSampled = uart_start;
            @(posedge clock);
            #2;
            if (startSampled) busyCnt = busyLen;
            else if (busyCnt > 0) busyCnt--;
            uart_busy = forceBusy || (busyCnt > 0);
        end
    end

    function automatic int rrPick(input logic [N-1:0] v, input logic [1:0] p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(p) + k) % N;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    typedef enum {M_IDLE, M_SEND, M_WAIT} mphase_t;
    mphase_t    mPhase = M_IDLE;
    bit         mWaitFirst = 1'b0;
    logic [1:0] mPtr = 2'd0;
    logic [1:0] mGrant = 2'd0;
    logic [7:0] mLast = 8'h00;
    logic [7:0] mBytes[$];
    logic [7:0] byteLog[$];
    int         grantLog[$];
    int         startCycle[$];
    int         cycle = 0;

    // Model: each accepted word becomes a queue of bytes; a byte goes out when the UART is free
    always @(negedge clock) begin : compare
        logic [N-1:0] expReady;
        logic         expStart;
        logic [7:0]   expData;
        int           w;
        cycle++;
        expReady = '0;
        expStart = 1'b0;
        expData  = mLast;
        w = 0;
        if (!reset) begin
            case (mPhase)
                M_IDLE: if (|req_valid) begin
                    w = rrPick(req_valid, mPtr);
                    expReady[w] = 1'b1;
                end
                M_SEND: if (!uart_busy) begin
                    expStart = 1'b1;
                    expData  = mBytes[0];
                end
                default: ;
            endcase
        end
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("uart_start", 32'(uart_start), 32'(expStart));
        checkOutput("uart_data", 32'(uart_data), 32'(expData));
        checkOutput("active", 32'(active), 32'(mPhase != M_IDLE));
        checkOutput("grant_id", 32'(grant_id), 32'(mGrant));
        if (uart_start) begin
            byteLog.push_back(uart_data);
            startCycle.push_back(cycle);
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) grantLog.push_back(i);
        if (reset) begin
            mPhase = M_IDLE;
            mPtr   = 2'd0;
            mGrant = 2'd0;
            mLast  = 8'h00;
            mBytes.delete();
        end else begin
            case (mPhase)
                M_IDLE: if (|req_valid) begin
                    mGrant = 2'(w);
                    mPtr   = 2'((w + 1) % N);
                    mBytes.delete();
                    mBytes.push_back(req_data[16*w +: 8]);
                    if (req_wide[w]) mBytes.push_back(req_data[16*w+8 +: 8]);
                    mPhase = M_SEND;
                end
                M_SEND: if (expStart) begin
                    mLast = mBytes.pop_front();
                    mWaitFirst = 1'b1;
                    mPhase = M_WAIT;
                end
                M_WAIT: begin
                    if (mWaitFirst) mWaitFirst = 1'b0;
                    else if (!uart_busy) mPhase = (mBytes.size() > 0) ? M_SEND : M_IDLE;
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] data, input logic wide, input logic valid);
        req_data[16*idx +: 16] = data;
        req_wide[idx] = wide;
        req_valid[idx] = valid;
    endtask

    task automatic waitAccepts(input int n, input string name);
        int budget = 0;
        while (grantLog.size() < n && budget < 300) begin
            tick();
            budget++;
        end
        checkOutput({name, "_accept"}, 32'(grantLog.size() >= n), 32'd1);
    endtask

    task automatic waitIdle(input string name);
        int budget = 0;
        while ((mPhase != M_IDLE || uart_busy) && budget < 300) begin
            tick();
            budget++;
        end
        checkOutput({name, "_idle"}, 32'(mPhase == M_IDLE && !uart_busy), 32'd1);
        tick();
    endtask

    initial begin
        int gb;
        int bb;
        int b;
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_data", 32'(uart_data), 32'h00);
        checkOutput("rst_grant", 32'(grant_id), 32'd0);
        checkOutput("rst_start", 32'(uart_start), 32'd0);
        reset = 1'b0;
        tick();

        // Single narrow word from requester 0
        applyStimulus(0, 16'h00A5, 1'b0, 1'b1);
        waitAccepts(1, "narrow");
        applyStimulus(0, 16'h00A5, 1'b0, 1'b0);
        waitIdle("narrow");
        checkOutput("narrow_count", 32'(byteLog.size()), 32'd1);
        checkOutput("narrow_byte", 32'(byteLog[0]), 32'hA5);
        checkOutput("narrow_grant", 32'(grantLog[0]), 32'd0);

        // Single wide word from requester 1: low byte, then high byte after busy falls
        applyStimulus(1, 16'h1234, 1'b1, 1'b1);
        waitAccepts(2, "wide");
        applyStimulus(1, 16'h1234, 1'b1, 1'b0);
        waitIdle("wide");
        checkOutput("wide_count", 32'(byteLog.size()), 32'd3);
        checkOutput("wide_lo", 32'(byteLog[1]), 32'h34);
        checkOutput("wide_hi", 32'(byteLog[2]), 32'h12);
        checkOutput("wide_grant", 32'(grantLog[1]), 32'd1);
        checkOutput("wide_gap", 32'(startCycle[2] - startCycle[1]), 32'd7);

        // Contention from ptr=0 with both requesters continuously valid
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        gb = grantLog.size();
        bb = byteLog.size();
        applyStimulus(0, 16'h0011, 1'b0, 1'b1);
        applyStimulus(1, 16'h0022, 1'b0, 1'b1);
        waitAccepts(gb + 4, "contend");
        applyStimulus(0, 16'h0011, 1'b0, 1'b0);
        applyStimulus(1, 16'h0022, 1'b0, 1'b0);
        waitIdle("contend");
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("contend_grant%0d", k), 32'(grantLog[gb+k]), 32'(k % 2));
            checkOutput($sformatf("contend_byte%0d", k), 32'(byteLog[bb+k]), (k % 2 == 0) ? 32'h11 : 32'h22);
        end

        // UART already busy when the frame enters its first send phase
        forceBusy = 1'b1;
        tick();
        tick();
        gb = grantLog.size();
        applyStimulus(0, 16'h00C3, 1'b0, 1'b1);
        waitAccepts(gb + 1, "busy");
        applyStimulus(0, 16'h00C3, 1'b0, 1'b0);
        bb = byteLog.size();
        repeat (10) tick();
        checkOutput("busy_hold_nostart", 32'(byteLog.size()), 32'(bb));
        forceBusy = 1'b0;
        waitIdle("busy");
        checkOutput("busy_release_count", 32'(byteLog.size()), 32'(bb + 1));
        checkOutput("busy_release_byte", 32'(byteLog[bb]), 32'hC3);

        // Reset while waiting on the low byte of a wide frame
        gb = grantLog.size();
        applyStimulus(1, 16'h1256, 1'b1, 1'b1);
        waitAccepts(gb + 1, "midrst");
        applyStimulus(1, 16'h1256, 1'b1, 1'b0);
        bb = byteLog.size();
        b = 0;
        while (byteLog.size() <= bb && b < 100) begin
            tick();
            b++;
        end
        checkOutput("midrst_first_byte", 32'(byteLog.size()), 32'(bb + 1));
        checkOutput("midrst_in_frame", 32'(active), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_active", 32'(active), 32'd0);
        checkOutput("midrst_grant", 32'(grant_id), 32'd0);
        checkOutput("midrst_data", 32'(uart_data), 32'h00);
        checkOutput("midrst_start", 32'(uart_start), 32'd0);
        checkOutput("midrst_ready", 32'(req_ready), 32'd0);
        repeat (30) tick();
        checkOutput("midrst_no_hi", 32'(byteLog.size()), 32'(bb + 1));
        gb = grantLog.size();
        applyStimulus(0, 16'h0033, 1'b0, 1'b1);
        applyStimulus(1, 16'h0044, 1'b0, 1'b1);
        waitAccepts(gb + 1, "midrst_ptr");
        applyStimulus(0, 16'h0033, 1'b0, 1'b0);
        applyStimulus(1, 16'h0044, 1'b0, 1'b0);
        checkOutput("midrst_ptr_zero", 32'(grantLog[gb]), 32'd0);
        waitIdle("midrst_ptr");

        // Requester 1 drops valid before ever being granted
        gb = grantLog.size();
        bb = byteLog.size();
        applyStimulus(0, 16'h0077, 1'b0, 1'b1);
        waitAccepts(gb + 1, "late");
        applyStimulus(0, 16'h0077, 1'b0, 1'b0);
        applyStimulus(1, 16'h0088, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1, 16'h0088, 1'b0, 1'b0);
        waitIdle("late");
        repeat (5) tick();
        checkOutput("late_grants", 32'(grantLog.size()), 32'(gb + 1));
        checkOutput("late_grant0", 32'(grantLog[gb]), 32'd0);
        checkOutput("late_bytes", 32'(byteLog.size()), 32'(bb + 1));
        checkOutput("late_byte", 32'(byteLog[bb]), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

endmodule
